// File: rtl/tdm_dmux8way16.sv
// Receive end of a slot-scanned TDM bus: tracks the frame slot, steers each
// accepted word into its channel register and flags framing errors.
module tdm_dmux8way16 #(
  parameter int W  = 16,
  parameter int N  = 8,
  parameter int SW = 3
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           in_valid,
  input  logic           in_sync,
  input  logic [W-1:0]   in_data,
  output logic [N*W-1:0] out_bus,
  output logic [N-1:0]   chan_stb,
  output logic           frame_done,
  output logic           sync_err,
  output logic [SW-1:0]  slot
);

  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [SW-1:0] SLOT_FIRST = SW'(0);
  localparam logic [SW-1:0] SLOT_NEXT  = SW'(1);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(N - 1);

  logic [0:0]    state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [N-1:0]  chan_stb_q, chan_stb_d;
  logic          frame_done_q, frame_done_d;
  logic          sync_err_q, sync_err_d;
  logic [W-1:0]  chan_q [N];

  logic          wr_en;
  logic [SW-1:0] wr_idx;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d      = state_q;
    slot_d       = slot_q;
    wr_en        = 1'b0;
    wr_idx       = SLOT_FIRST;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    chan_stb_d   = '0;

    if (in_valid) begin
      if (state_q == HUNT) begin
        if (in_sync) begin
          wr_en   = 1'b1;
          slot_d  = SLOT_NEXT;
          state_d = RUN;
        end
      end else if (in_sync) begin
        // A sync anywhere but slot 0 realigns the frame on this word.
        wr_en      = 1'b1;
        slot_d     = SLOT_NEXT;
        sync_err_d = (slot_q != SLOT_FIRST);
      end else if (slot_q == SLOT_FIRST) begin
        sync_err_d = 1'b1;
        slot_d     = SLOT_FIRST;
        state_d    = HUNT;
      end else begin
        wr_en        = 1'b1;
        wr_idx       = slot_q;
        slot_d       = slot_q + SLOT_NEXT;
        frame_done_d = (slot_q == SLOT_LAST);
      end
    end

    if (wr_en) chan_stb_d[wr_idx] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= HUNT;
      slot_q       <= SLOT_FIRST;
      chan_stb_q   <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      chan_stb_q   <= chan_stb_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  // NOTE: the channel array is reset because out_bus must read zero after reset; it is flops, not RAM.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N; k++) chan_q[k] <= '0;
    end else if (wr_en) begin
      chan_q[wr_idx] <= in_data;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_bus
    assign out_bus[g*W +: W] = chan_q[g];
  end

  assign chan_stb   = chan_stb_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign slot       = slot_q;

endmodule
